// File: rtl/instr_encoder_if.sv
// Descriptor input bus and instruction-memory write bus of instr_encoder.
// The slave modport is the encoder; the master modport is whoever feeds it
// descriptors and owns the memory's ready signal (bench or boot controller).
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic descriptors into RV32I words, buffers them in
// a small FIFO and writes them to sequential instruction-memory addresses.
// Optional feature macro: ENC_IMM_CHECK_EN (immediate range checking; when
// undefined, immediates are truncated and err_imm is tied low).
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              err_bad_op,
  output logic              err_imm
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ADDI = 4'd3,
    OP_ORI  = 4'd4,
    OP_SW   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_LUI  = 4'd7,
    OP_JAL  = 4'd8
  } op_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_S   = 7'b0100011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word;
  logic              op_ok;
  logic              imm_ok;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;

  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  // Combinational encode of the descriptor currently on the input bus.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    word  = '0;
    op_ok = 1'b1;
    case (bus.in_op)
      OP_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_SUB:  word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_AND:  word = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
      OP_ADDI: word = {imm[11:0], rs1, 3'b000, rd, OPC_I};
      OP_ORI:  word = {imm[11:0], rs1, 3'b110, rd, OPC_I};
      OP_SW:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_S};
      OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_B};
      OP_LUI:  word = {imm[31:12], rd, OPC_LUI};
      OP_JAL:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default: op_ok = 1'b0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  // Immediate range check: upper bits must be a sign extension of the field.
  always_comb begin
    imm_ok = 1'b1;
    case (bus.in_op)
      OP_ADDI, OP_ORI, OP_SW: imm_ok = (imm[31:11] == {21{imm[11]}});
      OP_BEQ:  imm_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      OP_JAL:  imm_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      OP_LUI:  imm_ok = (imm[11:0] == 12'd0);
      default: imm_ok = 1'b1;
    endcase
  end

  // Sticky immediate-violation flag, cleared by start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         err_imm <= 1'b0;
    else if (start)                   err_imm <= 1'b0;
    else if (accept && op_ok && !imm_ok) err_imm <= 1'b1;
  end
`else
  assign imm_ok  = 1'b1;
  assign err_imm = 1'b0;
`endif

  // in_ready looks only at registered occupancy and start, never at mem_ready.
  assign full         = (occ == (PTR_W+1)'(DEPTH));
  assign bus.in_ready = !full && !start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && op_ok && imm_ok;
  assign pop          = bus.mem_we && bus.mem_ready && !start;

  assign bus.mem_we    = (occ != '0);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.mem_we ? fifo_mem[rd_ptr] : 32'd0;
  assign busy          = bus.mem_we;

  // FIFO storage write; contents are only observed through occupancy-gated reads.
  // NOTE: the storage array has no reset; occ/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= word;
  end

  // Pointers, occupancy, write address, word count and bad-op flag.
  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      count      <= '0;
      err_bad_op <= 1'b0;
    end else if (start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      count      <= '0;
      err_bad_op <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        addr_q <= addr_q + 1'b1;
        count  <= count + 1'b1;
      end
      if (push && !pop)      occ <= occ + 1'b1;
      else if (!push && pop) occ <= occ - 1'b1;
      if (accept && !op_ok) err_bad_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed RV32I words.
module tb_instr_encoder;
  localparam int ADDR_W = 8;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, ADDI = 4'd3,
                         ORI = 4'd4, SW = 4'd5, BEQ = 4'd6, LUI = 4'd7,
                         JAL = 4'd8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [ADDR_W:0]  count;
  logic             busy;
  logic             err_bad_op;
  logic             err_imm;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] wlog [$];

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .count      (count),
    .busy       (busy),
    .err_bad_op (err_bad_op),
    .err_imm    (err_imm)
  );

  always #5 clk = ~clk;

  // Record every write that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (rst && !start && bus.mem_we && bus.mem_ready)
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic wait_accept(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, " accepted"}, 64'(ok), 64'd1);
  endtask

  task automatic send(input string tag, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    drive(op, rd, rs1, rs2, imm);
    wait_accept(tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, " drained"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    logic [ADDR_W+31:0] e;
    e = (wlog.size() != 0) ? wlog.pop_front() : 'x;
    check(tag, 64'(e), 64'({addr, data}));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.mem_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready",   64'(bus.in_ready),  64'd1);
    check("rst mem_we",     64'(bus.mem_we),    64'd0);
    check("rst mem_addr",   64'(bus.mem_addr),  64'd0);
    check("rst mem_wdata",  64'(bus.mem_wdata), 64'd0);
    check("rst count",      64'(count),         64'd0);
    check("rst busy",       64'(busy),          64'd0);
    check("rst err_bad_op", 64'(err_bad_op),    64'd0);
    check("rst err_imm",    64'(err_imm),       64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD then SUB, memory always ready
    bus.mem_ready = 1'b1;
    send("add", ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    check("latency mem_we",    64'(bus.mem_we),    64'd1);
    check("latency mem_wdata", 64'(bus.mem_wdata), 64'h002081B3);
    check("latency mem_addr",  64'(bus.mem_addr),  64'd0);
    send("sub", SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    wait_idle("add/sub");
    expect_write("wr add", 8'd0, 32'h002081B3);
    expect_write("wr sub", 8'd1, 32'h402081B3);
    check("count after 2", 64'(count), 64'd2);

    // I, U and B formats with unused fields set non-zero
    send("addi", ADDI, 5'd5, 5'd0, 5'd9, 32'hFFFF_FFFF);
    send("lui",  LUI,  5'd7, 5'd3, 5'd4, 32'h1234_5000);
    send("beq",  BEQ,  5'd4, 5'd1, 5'd2, 32'd8);
    wait_idle("i/u/b");
    expect_write("wr addi", 8'd2, 32'hFFF00293);
    expect_write("wr lui",  8'd3, 32'h123453B7);
    expect_write("wr beq",  8'd4, 32'h00208463);
    check("count after 5", 64'(count), 64'd5);

    // Backpressure: fill the FIFO, hold a fifth descriptor
    bus.mem_ready = 1'b0;
    send("and", AND, 5'd4, 5'd5, 5'd6, 32'd0);
    send("ori", ORI, 5'd1, 5'd2, 5'd7, 32'h0000_00F0);
    send("sw",  SW,  5'd9, 5'd2, 5'd3, 32'hFFFF_FFFC);
    send("jal", JAL, 5'd1, 5'd7, 5'd7, 32'd16);
    check("full in_ready",  64'(bus.in_ready),  64'd0);
    check("full busy",      64'(busy),          64'd1);
    check("full mem_addr",  64'(bus.mem_addr),  64'd5);
    check("full mem_wdata", 64'(bus.mem_wdata), 64'h0062F233);
    drive(ADD, 5'd10, 5'd11, 5'd12, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stall in_ready",  64'(bus.in_ready),  64'd0);
    check("stall mem_wdata", 64'(bus.mem_wdata), 64'h0062F233);
    check("stall mem_addr",  64'(bus.mem_addr),  64'd5);
    check("stall count",     64'(count),         64'd5);
    bus.mem_ready = 1'b1;
    wait_accept("fifth");
    wait_idle("backpressure");
    expect_write("wr and",  8'd5, 32'h0062F233);
    expect_write("wr ori",  8'd6, 32'h0F016093);
    expect_write("wr sw",   8'd7, 32'hFE312E23);
    expect_write("wr jal",  8'd8, 32'h010000EF);
    expect_write("wr add5", 8'd9, 32'h00C58533);
    check("count after 10", 64'(count), 64'd10);

    // Invalid op
    send("badop", 4'd12, 5'd1, 5'd1, 5'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("badop busy",    64'(busy),        64'd0);
    check("badop flag",    64'(err_bad_op),  64'd1);
    check("badop count",   64'(count),       64'd10);
    check("badop nowrite", 64'(wlog.size()), 64'd0);

    // Out-of-range I immediate
    send("addi2048", ADDI, 5'd0, 5'd0, 5'd0, 32'd2048);
    wait_idle("addi2048");
`ifdef ENC_IMM_CHECK_EN
    check("imm err_imm", 64'(err_imm),     64'd1);
    check("imm nowrite", 64'(wlog.size()), 64'd0);
`else
    expect_write("wr addi2048", 8'd10, 32'h80000013);
    check("imm err_imm", 64'(err_imm), 64'd0);
`endif
    check("badop sticky", 64'(err_bad_op), 64'd1);

    // start abandons a pending write and restores the initial state
    bus.mem_ready = 1'b0;
    send("pre-start", ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    check("pre-start busy", 64'(busy), 64'd1);
    start = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("start in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    #1;
    check("start busy",       64'(busy),        64'd0);
    check("start mem_addr",   64'(bus.mem_addr), 64'd0);
    check("start count",      64'(count),       64'd0);
    check("start err_bad_op", 64'(err_bad_op),  64'd0);
    check("start err_imm",    64'(err_imm),     64'd0);
    check("start nowrite",    64'(wlog.size()), 64'd0);
    send("post-start", ADDI, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    wait_idle("post-start");
    expect_write("wr post-start", 8'd0, 32'hFFF00293);
    check("post-start count", 64'(count), 64'd1);

    // Reset in the middle of a stalled transfer
    bus.mem_ready = 1'b0;
    send("buf0", ADD,  5'd3, 5'd1, 5'd2, 32'd0);
    send("buf1", SUB,  5'd3, 5'd1, 5'd2, 32'd0);
    send("buf2", ADDI, 5'd5, 5'd0, 5'd0, 32'd1);
    check("buffered busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst mem_we",   64'(bus.mem_we),   64'd0);
    check("midrst busy",     64'(busy),         64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("postrst count",    64'(count),        64'd0);
    check("postrst mem_addr", 64'(bus.mem_addr), 64'd0);
    send("postrst lui", LUI, 5'd7, 5'd0, 5'd0, 32'h1234_5000);
    wait_idle("postrst");
    expect_write("wr postrst", 8'd0, 32'h123453B7);
    check("postrst count1", 64'(count),       64'd1);
    check("no stray writes", 64'(wlog.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
